// File: rtl/ppu_sync_monitor.sv
// rtl/ppu_sync_monitor.sv - PPU2 blanking resynchroniser, line/frame timing monitor and lock tracker
// Optional LED pulse stretching: define PPU_SYNC_MONITOR_LED_STRETCH_EN.
module ppu_sync_monitor #(
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 16,
  parameter int STRETCH_CYCLES = 1200000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             xin_tick,
  input  logic             ppu2_vblank,
  input  logic             ppu2_hblank,
  input  logic             clear_error,
  output logic [CNT_W-1:0] line_length,
  output logic [CNT_W-1:0] frame_lines,
  output logic [CNT_W-1:0] frame_count,
  output logic             locked,
  output logic             sync_error,
  output logic             led7,
  output logic             led8
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_LOCKED} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Reject configurations the synchroniser and stretcher cannot support.
  if (SYNC_STAGES < 2 || STRETCH_CYCLES < 1) begin : g_bad_param
    $error("ppu_sync_monitor: SYNC_STAGES must be >= 2 and STRETCH_CYCLES >= 1");
  end

  state_e           state_q, state_d;
  logic [SYNC_STAGES-1:0] vb_sync_q, hb_sync_q;
  logic             vb_prev_q, hb_prev_q;
  logic             vb_lvl, hb_lvl, vb_rise, hb_rise;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d, lines_cnt_q, lines_cnt_d;
  logic [CNT_W-1:0] line_length_q, line_length_d, frame_lines_q, frame_lines_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d, ref_lines_q, ref_lines_d;
  logic [CNT_W-1:0] line_total, lines_total;
  logic             sync_error_q, sync_error_d, err_set, timeout;

  // Resynchronise the asynchronous blank inputs and keep the previous level for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vb_sync_q <= '0;
      hb_sync_q <= '0;
      vb_prev_q <= 1'b0;
      hb_prev_q <= 1'b0;
    end else begin
      vb_sync_q <= {vb_sync_q[SYNC_STAGES-2:0], ppu2_vblank};
      hb_sync_q <= {hb_sync_q[SYNC_STAGES-2:0], ppu2_hblank};
      vb_prev_q <= vb_lvl;
      hb_prev_q <= hb_lvl;
    end
  end

  assign vb_lvl  = vb_sync_q[SYNC_STAGES-1];
  assign hb_lvl  = hb_sync_q[SYNC_STAGES-1];
  assign vb_rise = vb_lvl & ~vb_prev_q;
  assign hb_rise = hb_lvl & ~hb_prev_q;

  // Saturating totals include the event arriving in the closing cycle.
  assign line_total  = (line_cnt_q == CNT_MAX)  ? CNT_MAX : line_cnt_q + CNT_W'(xin_tick);
  assign lines_total = (lines_cnt_q == CNT_MAX) ? CNT_MAX : lines_cnt_q + CNT_W'(hb_rise);
  assign timeout     = (state_q != ST_IDLE) && (line_cnt_q == CNT_MAX);

  // Measurement counters: capture totals on blank edges, otherwise keep counting.
  always_comb begin
    line_cnt_d    = line_total;
    line_length_d = line_length_q;
    lines_cnt_d   = lines_total;
    frame_lines_d = frame_lines_q;
    frame_count_d = frame_count_q;
    if (hb_rise) begin
      line_length_d = line_total;
      line_cnt_d    = '0;
    end
    if (vb_rise) begin
      frame_lines_d = lines_total;
      lines_cnt_d   = '0;
      if (state_q != ST_IDLE) frame_count_d = frame_count_q + CNT_W'(1);
    end
  end

  // Lock FSM next state, reference capture and sticky error with set-over-clear priority.
  always_comb begin
    state_d     = state_q;
    ref_lines_d = ref_lines_q;
    err_set     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vb_rise) state_d = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (vb_rise) begin
          ref_lines_d = lines_total;
          state_d     = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (vb_rise) begin
          if (lines_total != ref_lines_q) err_set = 1'b1;
          ref_lines_d = lines_total;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (timeout) begin
      err_set = 1'b1;
      state_d = ST_IDLE;
    end
    sync_error_d = err_set ? 1'b1 : (clear_error ? 1'b0 : sync_error_q);
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_cnt_q    <= '0;
      lines_cnt_q   <= '0;
      line_length_q <= '0;
      frame_lines_q <= '0;
      frame_count_q <= '0;
      ref_lines_q   <= '0;
      sync_error_q  <= 1'b0;
    end else begin
      line_cnt_q    <= line_cnt_d;
      lines_cnt_q   <= lines_cnt_d;
      line_length_q <= line_length_d;
      frame_lines_q <= frame_lines_d;
      frame_count_q <= frame_count_d;
      ref_lines_q   <= ref_lines_d;
      sync_error_q  <= sync_error_d;
    end
  end

  assign line_length = line_length_q;
  assign frame_lines = frame_lines_q;
  assign frame_count = frame_count_q;
  assign sync_error  = sync_error_q;
  assign locked      = (state_q == ST_LOCKED);

`ifdef PPU_SYNC_MONITOR_LED_STRETCH_EN
  localparam int STRETCH_W = $clog2(STRETCH_CYCLES + 1);
  localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(STRETCH_CYCLES);

  logic [STRETCH_W-1:0] led7_cnt_q, led7_cnt_d, led8_cnt_q, led8_cnt_d;

  // Pulse stretchers: reload on every edge, count down to zero otherwise.
  always_comb begin
    led7_cnt_d = (led7_cnt_q != '0) ? led7_cnt_q - STRETCH_W'(1) : '0;
    led8_cnt_d = (led8_cnt_q != '0) ? led8_cnt_q - STRETCH_W'(1) : '0;
    if (vb_rise) led7_cnt_d = STRETCH_LOAD;
    if (hb_rise) led8_cnt_d = STRETCH_LOAD;
  end

  // Stretch counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led7_cnt_q <= '0;
      led8_cnt_q <= '0;
    end else begin
      led7_cnt_q <= led7_cnt_d;
      led8_cnt_q <= led8_cnt_d;
    end
  end

  assign led7 = (led7_cnt_q != '0);
  assign led8 = (led8_cnt_q != '0);
`else
  assign led7 = vb_lvl;
  assign led8 = hb_lvl;
`endif

endmodule

// File: tb/tb_ppu_sync_monitor.sv
// tb/tb_ppu_sync_monitor.sv - table-driven self-checking bench for ppu_sync_monitor
module tb_ppu_sync_monitor;

  logic        clock = 1'b0;
  logic        reset_n, xin_tick, ppu2_vblank, ppu2_hblank, clear_error;
  logic [15:0] line_length, frame_lines, frame_count;
  logic        locked, sync_error, led7, led8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  ppu_sync_monitor #(
    .SYNC_STAGES   (2),
    .CNT_W         (16),
    .STRETCH_CYCLES(10)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .xin_tick   (xin_tick),
    .ppu2_vblank(ppu2_vblank),
    .ppu2_hblank(ppu2_hblank),
    .clear_error(clear_error),
    .line_length(line_length),
    .frame_lines(frame_lines),
    .frame_count(frame_count),
    .locked     (locked),
    .sync_error (sync_error),
    .led7       (led7),
    .led8       (led8)
  );

  typedef struct {
    int          lines;
    bit          clr_before;
    bit          clr_at_vb;
    bit          sim;
    bit          pre_lk;
    logic [15:0] exp_fl;
    bit          exp_lk;
    bit          exp_err;
    logic [15:0] exp_fc;
  } frame_t;

  frame_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".line_length"}, 32'(line_length), 0);
    check({tag, ".frame_lines"}, 32'(frame_lines), 0);
    check({tag, ".frame_count"}, 32'(frame_count), 0);
    check({tag, ".locked"},      32'(locked), 0);
    check({tag, ".sync_error"},  32'(sync_error), 0);
    check({tag, ".led7"},        32'(led7), 0);
    check({tag, ".led8"},        32'(led8), 0);
  endtask

  task automatic run_frame(input int idx);
    frame_t r;
    int     nl;
    r  = tbl[idx];
    nl = r.sim ? r.lines - 1 : r.lines;
    if (r.clr_before) begin
      clear_error = 1'b1;
      cyc(1);
      clear_error = 1'b0;
      cyc(1);
      check($sformatf("frame%0d.cleared", idx), 32'(sync_error), 0);
    end
    for (int l = 0; l < nl; l++) begin
      ppu2_hblank = 1'b1;
      cyc(2);
      ppu2_hblank = 1'b0;
      cyc(2);
    end
    if (r.sim) ppu2_hblank = 1'b1;
    ppu2_vblank = 1'b1;
    cyc(2);
    if (r.clr_at_vb) clear_error = 1'b1;
    check($sformatf("frame%0d.locked_pre", idx), 32'(locked), 32'(r.pre_lk));
    cyc(1);
    clear_error = 1'b0;
    check($sformatf("frame%0d.locked", idx),      32'(locked), 32'(r.exp_lk));
    check($sformatf("frame%0d.frame_lines", idx), 32'(frame_lines), 32'(r.exp_fl));
    check($sformatf("frame%0d.sync_error", idx),  32'(sync_error), 32'(r.exp_err));
    check($sformatf("frame%0d.frame_count", idx), 32'(frame_count), 32'(r.exp_fc));
    cyc(1);
    ppu2_hblank = 1'b0;
    ppu2_vblank = 1'b0;
    cyc(4);
  endtask

  task automatic led_count(input bit use_v, input bit dbl, input int width, output int n);
    logic lvl;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock);
      #1;
      lvl = dbl ? ((c < 2) || (c >= 5 && c < 7)) : (c < width);
      if (use_v) ppu2_vblank = lvl;
      else       ppu2_hblank = lvl;
      @(negedge clock);
      n += use_v ? int'(led7) : int'(led8);
    end
    ppu2_vblank = 1'b0;
    ppu2_hblank = 1'b0;
  endtask

  initial begin
    int n;
    //                lines clrB clrV sim pre  fl   lk err  fc
    tbl[0] = '{100, 1'b0, 1'b0, 1'b0, 1'b0, 16'd100, 1'b0, 1'b0, 16'd0};
    tbl[1] = '{262, 1'b0, 1'b0, 1'b0, 1'b0, 16'd262, 1'b1, 1'b0, 16'd1};
    tbl[2] = '{262, 1'b0, 1'b0, 1'b0, 1'b1, 16'd262, 1'b1, 1'b0, 16'd2};
    tbl[3] = '{263, 1'b0, 1'b0, 1'b0, 1'b1, 16'd263, 1'b1, 1'b1, 16'd3};
    tbl[4] = '{263, 1'b0, 1'b0, 1'b0, 1'b1, 16'd263, 1'b1, 1'b1, 16'd4};
    tbl[5] = '{263, 1'b1, 1'b0, 1'b0, 1'b1, 16'd263, 1'b1, 1'b0, 16'd5};
    tbl[6] = '{262, 1'b0, 1'b1, 1'b0, 1'b1, 16'd262, 1'b1, 1'b1, 16'd6};
    tbl[7] = '{262, 1'b1, 1'b0, 1'b1, 1'b1, 16'd262, 1'b1, 1'b0, 16'd7};

    reset_n     = 1'b0;
    xin_tick    = 1'b0;
    ppu2_vblank = 1'b0;
    ppu2_hblank = 1'b0;
    clear_error = 1'b0;
    cyc(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    cyc(2);

    // Line length: tick every 4 clocks, hblank rise every 341 ticks.
    for (int c = 0; c < 2 * 1364 + 20; c++) begin
      xin_tick    = (c % 4 == 0);
      ppu2_hblank = ((c % 1364) < 8);
      cyc(1);
    end
    xin_tick    = 1'b0;
    ppu2_hblank = 1'b0;
    check("line_length_341", 32'(line_length), 341);
    check("idle_not_locked", 32'(locked), 0);

    // Mid-stream asynchronous reset.
    ppu2_hblank = 1'b1;
    cyc(1);
    ppu2_hblank = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    cyc(2);
    reset_n = 1'b1;
    cyc(3);

    for (int i = 0; i < 8; i++) run_frame(i);

    // One short line with 7 ticks, then the timeout.
    xin_tick = 1'b1;
    cyc(7);
    xin_tick    = 1'b0;
    ppu2_hblank = 1'b1;
    cyc(2);
    ppu2_hblank = 1'b0;
    cyc(3);
    check("line_length_7", 32'(line_length), 7);
    xin_tick = 1'b1;
    cyc(65000);
    check("pre_timeout.locked", 32'(locked), 1);
    check("pre_timeout.sync_error", 32'(sync_error), 0);
    cyc(545);
    xin_tick = 1'b0;
    cyc(1);
    check("timeout.sync_error",  32'(sync_error), 1);
    check("timeout.locked",      32'(locked), 0);
    check("timeout.line_length", 32'(line_length), 7);
    check("timeout.frame_lines", 32'(frame_lines), 262);
    check("timeout.frame_count", 32'(frame_count), 7);

    // LED behaviour.
    led_count(1'b1, 1'b0, 4, n);
`ifdef PPU_SYNC_MONITOR_LED_STRETCH_EN
    check("led7_single", 32'(n), 10);
`else
    check("led7_single", 32'(n), 4);
`endif
    led_count(1'b1, 1'b1, 0, n);
`ifdef PPU_SYNC_MONITOR_LED_STRETCH_EN
    check("led7_retrigger", 32'(n), 15);
`else
    check("led7_retrigger", 32'(n), 4);
`endif
    led_count(1'b0, 1'b0, 3, n);
`ifdef PPU_SYNC_MONITOR_LED_STRETCH_EN
    check("led8_single", 32'(n), 10);
`else
    check("led8_single", 32'(n), 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
